nn_input_sequencer: RTL and testbench

NN_INPUT_SEQUENCER -- requirements
Module: nn_input_sequencer

---
 rtl/nn_input_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_nn_input_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_input_sequencer.sv
// Avalon-MM front end that streams host words into the network input buffer RAM
// through a small staging FIFO, then kicks the network core and waits for completion.
module nn_input_sequencer #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              nn_start,
  input  logic              nn_done,
  output logic              irq
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LvlW = PtrW + 1;
  localparam logic [LvlW-1:0] LvlFull = LvlW'(FIFO_DEPTH);
  localparam logic [10:0] LenMax = 11'd1024;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StRun  = 2'd2,
    StWait = 2'd3
  } state_e;

  state_e              r_state;
  logic [ADDR_W-1:0]   r_base;
  logic [10:0]         r_len;
  logic [10:0]         r_count;
  logic [LvlW-1:0]     r_level;
  logic [PtrW-1:0]     r_rd_ptr;
  logic [PtrW-1:0]     r_wr_ptr;
  logic                r_done;
  logic                r_err_cfg;
  logic                r_err_ovf;
  logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];

  logic w_wr;
  logic w_wr_ctrl;
  logic w_wr_data;
  logic w_abort;
  logic w_start;
  logic w_clear;
  logic w_len_ok;
  logic w_push;
  logic w_pop;
  logic w_last;
  logic w_go;
  logic w_flush;
  logic w_busy;

  // Bus decode
  assign w_wr      = chipselect && !write_n;
  assign w_wr_ctrl = w_wr && (address == 2'd0);
  assign w_wr_data = w_wr && (address == 2'd3);
  assign w_abort   = w_wr_ctrl && writedata[1];
  assign w_start   = w_wr_ctrl && writedata[0] && !writedata[1];
  assign w_clear   = w_wr_ctrl && writedata[2];
  assign w_len_ok  = (r_len != 11'd0) && (r_len <= LenMax);
  assign w_busy    = (r_state != StIdle);

  // Push decision uses the level before any same-cycle pop, so a full FIFO drops the word.
  assign w_push  = w_wr_data && (r_state == StLoad) && (r_level != LvlFull);
  assign w_pop   = !reset && !w_abort && (r_state == StLoad) && (r_level != '0);
  assign w_last  = w_pop && ((r_count + 11'd1) == r_len);
  assign w_go    = (r_state == StIdle) && w_start && w_len_ok;
  assign w_flush = w_abort || w_last || w_go;

  // RAM write port is driven straight from the FIFO head
  assign ram_we    = w_pop;
  assign ram_wdata = r_mem[r_rd_ptr];
  assign ram_addr  = r_base + r_count[ADDR_W-1:0];
  assign nn_start  = !reset && !w_abort && (r_state == StRun);
  assign irq       = !reset && r_done;

  always_comb begin
    readdata = '0;
    unique case (address)
      2'd0: readdata = {26'b0, r_err_ovf, r_err_cfg, r_done, w_busy, r_state};
      2'd1: readdata[ADDR_W-1:0] = r_base;
      2'd2: readdata[10:0] = r_len;
      2'd3: begin
        readdata[15:5]      = r_count;
        readdata[LvlW-1:0]  = r_level;
      end
      default: readdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= writedata[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_level  <= '0;
    end else if (w_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_level <= r_level + LvlW'(w_push) - LvlW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= StIdle;
      r_base    <= '0;
      r_len     <= '0;
      r_count   <= '0;
      r_done    <= 1'b0;
      r_err_cfg <= 1'b0;
      r_err_ovf <= 1'b0;
    end else begin
      // Clearing happens first so a same-cycle event can still raise its flag.
      if (w_clear) begin
        r_done    <= 1'b0;
        r_err_cfg <= 1'b0;
        r_err_ovf <= 1'b0;
      end
      if (w_wr_data && !w_push) begin
        r_err_ovf <= 1'b1;
      end
      if (w_wr && (address == 2'd1) && !w_busy) begin
        r_base <= writedata[ADDR_W-1:0];
      end
      if (w_wr && (address == 2'd2) && !w_busy) begin
        r_len <= writedata[10:0];
      end
      if (w_pop) begin
        r_count <= r_count + 11'd1;
      end

      unique case (r_state)
        StIdle: begin
          if (w_start) begin
            if (w_len_ok) begin
              r_count <= '0;
              r_done  <= 1'b0;
              r_state <= StLoad;
            end else begin
              r_err_cfg <= 1'b1;
            end
          end
        end
        StLoad: begin
          if (w_last) begin
            r_state <= StRun;
          end
        end
        StRun: begin
          r_state <= StWait;
        end
        StWait: begin
          if (nn_done) begin
            r_done  <= 1'b1;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase

      if (w_abort) begin
        r_state <= StIdle;
      end
    end
  end

endmodule

// File: tb/tb_nn_input_sequencer.sv
// Randomised bench for nn_input_sequencer: a queue-based model predicts every output each
// cycle, and directed scenarios pin the model with hand-computed values.
module tb_nn_input_sequencer;

  logic        clk;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_we;
  logic        nn_start;
  logic        nn_done;
  logic        irq;

  nn_input_sequencer #(
    .ADDR_W    (10),
    .DATA_W    (32),
    .FIFO_DEPTH(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .nn_start  (nn_start),
    .nn_done   (nn_done),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: 0 idle, 1 load, 2 run, 3 wait
  int          m_state, m_base, m_len, m_count;
  int          m_done, m_cfg, m_ovf;
  logic [31:0] m_q[$];

  // Observed RAM writes and start pulses, used by directed checks
  int          log_addr[$];
  logic [31:0] log_data[$];
  int          start_cnt;
  logic [31:0] last_rd;
  logic        last_irq;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_base = 0; m_len = 0; m_count = 0;
    m_done = 0; m_cfg = 0; m_ovf = 0;
    m_q.delete();
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0: return 32'((m_ovf << 5) | (m_cfg << 4) | (m_done << 3) |
                       ((m_state != 0) ? 4 : 0) | m_state);
      2'd1: return 32'(m_base);
      2'd2: return 32'(m_len);
      default: return 32'((m_count << 5) | m_q.size());
    endcase
  endfunction

  // One bus cycle: drive, compare every output against the model, then advance both.
  task automatic cyc(input logic cs, input logic wn, input logic [1:0] a,
                     input logic [31:0] wd, input logic dn, input logic rs);
    logic wr, abort, start, clr, exp_we, exp_st, exp_irq;
    int   lvl;
    chipselect = cs; write_n = wn; address = a; writedata = wd; nn_done = dn; reset = rs;
    #3;
    wr    = cs && !wn;
    abort = wr && (a == 2'd0) && wd[1];
    start = wr && (a == 2'd0) && wd[0] && !wd[1];
    clr   = wr && (a == 2'd0) && wd[2];
    exp_we  = !rs && !abort && (m_state == 1) && (m_q.size() > 0);
    exp_st  = !rs && !abort && (m_state == 2);
    exp_irq = !rs && (m_done != 0);
    chk("ram_we", 32'(ram_we), 32'(exp_we));
    chk("nn_start", 32'(nn_start), 32'(exp_st));
    chk("irq", 32'(irq), 32'(exp_irq));
    chk("readdata", readdata, model_read(a));
    if (exp_we) begin
      chk("ram_addr", 32'(ram_addr), 32'((m_base + m_count) % 1024));
      chk("ram_wdata", ram_wdata, m_q[0]);
    end
    if (ram_we) begin
      log_addr.push_back(int'(ram_addr));
      log_data.push_back(ram_wdata);
    end
    if (nn_start) start_cnt++;
    last_rd  = readdata;
    last_irq = irq;

    if (rs) begin
      model_reset();
    end else begin
      lvl = m_q.size();
      if (exp_we) begin
        void'(m_q.pop_front());
        m_count++;
      end
      if (clr) begin
        m_done = 0; m_cfg = 0; m_ovf = 0;
      end
      if (wr && a == 2'd3) begin
        if (m_state == 1 && lvl < 4) m_q.push_back(wd);
        else m_ovf = 1;
      end
      if (wr && a == 2'd1 && m_state == 0) m_base = int'(wd & 32'h3FF);
      if (wr && a == 2'd2 && m_state == 0) m_len = int'(wd & 32'h7FF);
      case (m_state)
        0: if (start) begin
          if (m_len >= 1 && m_len <= 1024) begin
            m_count = 0; m_done = 0; m_state = 1; m_q.delete();
          end else begin
            m_cfg = 1;
          end
        end
        1: if (exp_we && m_count == m_len) begin
          m_state = 2; m_q.delete();
        end
        2: m_state = 3;
        default: if (dn) begin
          m_done = 1; m_state = 0;
        end
      endcase
      if (abort) begin
        m_state = 0; m_q.delete();
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cyc(1'b1, 1'b0, a, d, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [1:0] a);
    cyc(1'b1, 1'b1, a, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 2'd0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    start_cnt = 0;
  endtask

  initial begin
    chipselect = 1'b0; write_n = 1'b1; address = 2'd0; writedata = '0;
    nn_done = 1'b0; reset = 1'b1;
    model_reset();
    clear_log();
    @(posedge clk);
    #1;
    cyc(1'b0, 1'b1, 2'd0, 32'h0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 2'd0, 32'h0, 1'b0, 1'b1);

    // Reset values
    for (int a = 0; a < 4; a++) begin
      rd(2'(a));
      chk("reset_reg", last_rd, 32'h0);
    end

    // Basic three-word load
    wr(2'd1, 32'h010);
    wr(2'd2, 32'd3);
    clear_log();
    wr(2'd0, 32'h1);
    wr(2'd3, 32'hAAAA_0001);
    wr(2'd3, 32'hBBBB_0002);
    wr(2'd3, 32'hCCCC_0003);
    idle(4);
    rd(2'd0);
    chk("wait_status", last_rd, 32'h07);
    chk("basic_nwr", 32'(log_addr.size()), 32'd3);
    if (log_addr.size() == 3) begin
      chk("basic_a0", 32'(log_addr[0]), 32'h010);
      chk("basic_a2", 32'(log_addr[2]), 32'h012);
      chk("basic_d0", log_data[0], 32'hAAAA_0001);
      chk("basic_d1", log_data[1], 32'hBBBB_0002);
      chk("basic_d2", log_data[2], 32'hCCCC_0003);
    end
    chk("basic_starts", 32'(start_cnt), 32'd1);
    cyc(1'b0, 1'b1, 2'd0, 32'h0, 1'b1, 1'b0);
    rd(2'd0);
    chk("done_status", last_rd, 32'h08);
    chk("done_irq", 32'(last_irq), 32'd1);

    // Address wrap
    wr(2'd0, 32'h4);
    wr(2'd1, 32'h3FE);
    wr(2'd2, 32'd4);
    clear_log();
    wr(2'd0, 32'h1);
    for (int i = 0; i < 4; i++) wr(2'd3, 32'h5000 + 32'(i));
    idle(4);
    chk("wrap_nwr", 32'(log_addr.size()), 32'd4);
    if (log_addr.size() == 4) begin
      chk("wrap_a1", 32'(log_addr[1]), 32'h3FF);
      chk("wrap_a2", 32'(log_addr[2]), 32'h000);
      chk("wrap_a3", 32'(log_addr[3]), 32'h001);
    end
    cyc(1'b0, 1'b1, 2'd0, 32'h0, 1'b1, 1'b0);

    // Bad lengths
    wr(2'd0, 32'h4);
    wr(2'd2, 32'd0);
    clear_log();
    wr(2'd0, 32'h1);
    idle(2);
    rd(2'd0);
    chk("len0_status", last_rd, 32'h10);
    wr(2'd0, 32'h4);
    wr(2'd2, 32'd1025);
    wr(2'd0, 32'h1);
    idle(2);
    rd(2'd0);
    chk("len1025_status", last_rd, 32'h10);
    rd(2'd2);
    chk("len1025_reg", last_rd, 32'd1025);
    chk("badlen_nwr", 32'(log_addr.size()), 32'd0);

    // DATA outside LOAD is dropped
    wr(2'd0, 32'h4);
    wr(2'd3, 32'hDEAD_BEEF);
    idle(2);
    rd(2'd0);
    chk("ovf_status", last_rd, 32'h20);
    chk("ovf_nwr", 32'(log_addr.size()), 32'd0);

    // Abort with a word still staged
    wr(2'd0, 32'h4);
    wr(2'd1, 32'h100);
    wr(2'd2, 32'd8);
    clear_log();
    wr(2'd0, 32'h1);
    wr(2'd3, 32'h1111);
    wr(2'd3, 32'h2222);
    wr(2'd0, 32'h2);
    rd(2'd0);
    chk("abort_status", last_rd, 32'h00);
    rd(2'd3);
    chk("abort_progress", last_rd, 32'h20);
    idle(3);
    chk("abort_nwr", 32'(log_addr.size()), 32'd1);
    chk("abort_starts", 32'(start_cnt), 32'd0);
    clear_log();
    wr(2'd0, 32'h3);
    rd(2'd0);
    chk("abort_start_status", last_rd, 32'h00);
    wr(2'd0, 32'h1);
    wr(2'd3, 32'h3333);
    idle(2);
    chk("restart_nwr", 32'(log_addr.size()), 32'd1);
    if (log_addr.size() == 1) chk("restart_addr", 32'(log_addr[0]), 32'h100);
    wr(2'd0, 32'h2);

    // Reset in WAIT
    wr(2'd0, 32'h4);
    wr(2'd3, 32'h0);
    wr(2'd2, 32'd1);
    wr(2'd0, 32'h1);
    wr(2'd3, 32'h4444);
    idle(4);
    rd(2'd0);
    chk("wait_flags_status", last_rd, 32'h27);
    cyc(1'b0, 1'b1, 2'd0, 32'h0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 2'd0, 32'h0, 1'b1, 1'b0);
    rd(2'd0);
    chk("post_reset_status", last_rd, 32'h00);
    chk("post_reset_irq", 32'(last_irq), 32'd0);

    // Randomised traffic
    for (int i = 0; i < 4000; i++) begin
      int          pick;
      logic [31:0] d;
      logic        dn;
      pick = int'($urandom_range(0, 99));
      dn   = ($urandom_range(0, 7) == 0);
      d    = $urandom;
      if (pick < 1) begin
        cyc(1'b0, 1'b1, 2'd0, 32'h0, dn, 1'b1);
      end else if (pick < 36) begin
        cyc(1'b1, 1'b0, 2'd3, d, dn, 1'b0);
      end else if (pick < 46) begin
        d = {29'(d >> 3), ($urandom_range(0, 3) == 0), ($urandom_range(0, 11) == 0),
             ($urandom_range(0, 1) == 0)};
        cyc(1'b1, 1'b0, 2'd0, d, dn, 1'b0);
      end else if (pick < 52) begin
        cyc(1'b1, 1'b0, 2'd1, d, dn, 1'b0);
      end else if (pick < 60) begin
        d = (d & 32'hFFFF_F800) | (($urandom_range(0, 19) == 0) ?
            32'(1024 + $urandom_range(0, 1)) : 32'($urandom_range(0, 10)));
        cyc(1'b1, 1'b0, 2'd2, d, dn, 1'b0);
      end else if (pick < 80) begin
        cyc(1'b1, 1'b1, 2'($urandom_range(0, 3)), d, dn, 1'b0);
      end else begin
        cyc(1'b0, 1'b1, 2'($urandom_range(0, 3)), d, dn, 1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
